// File: rtl/ksa_fsm_if.sv
// S-array RAM port: the KSA engine is the master, the RAM (or a model of it) is the slave.
interface ksa_fsm_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              wren;
  logic [7:0]        rdata;

  modport master (output addr, wdata, wren, input rdata);
  modport slave  (input addr, wdata, wren, output rdata);
endinterface

// File: rtl/ksa_fsm.sv
// RC4 key-scheduling engine: fills the S-array with the identity permutation,
// then runs the 256-iteration swap loop over a 1-cycle-latency synchronous RAM.
module ksa_fsm #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  ksa_fsm_if.master              mem,
  output logic                   busy,
  output logic                   done
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST   = {ADDR_W{1'b1}};
  localparam logic [KIDX_W-1:0] KLAST  = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, READ_SI, WAIT_SI, READ_SJ, WAIT_SJ, WRITE_SI, WRITE_SJ, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [7:0]        si_q, si_d, sj_q, sj_d;

  logic [ADDR_W-1:0] addr_o;
  logic [7:0]        wdata_o;
  logic              wren_o;

  // key[0] is the most-significant byte of secret_key
  logic [7:0] key_b [KEY_BYTES];
  for (genvar n = 0; n < KEY_BYTES; n++) begin : g_key
    assign key_b[n] = secret_key[(KEY_BYTES-n)*8-1 -: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    addr_o  = '0;
    wdata_o = '0;
    wren_o  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = INIT;
          i_d     = '0;
        end
      end
      INIT: begin
        addr_o  = i_q;
        wdata_o = 8'(i_q);
        wren_o  = 1'b1;
        if (i_q == LAST) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = READ_SI;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      READ_SI: begin
        addr_o  = i_q;
        state_d = WAIT_SI;
      end
      WAIT_SI: begin
        // rdata now holds S[i]; the new j is what READ_SJ presents next cycle
        addr_o  = i_q;
        si_d    = mem.rdata;
        j_d     = j_q + ADDR_W'(mem.rdata) + ADDR_W'(key_b[kidx_q]);
        state_d = READ_SJ;
      end
      READ_SJ: begin
        addr_o  = j_q;
        state_d = WAIT_SJ;
      end
      WAIT_SJ: begin
        addr_o  = j_q;
        sj_d    = mem.rdata;
        state_d = WRITE_SI;
      end
      WRITE_SI: begin
        addr_o  = i_q;
        wdata_o = sj_q;
        wren_o  = 1'b1;
        state_d = WRITE_SJ;
      end
      WRITE_SJ: begin
        addr_o  = j_q;
        wdata_o = si_q;
        wren_o  = 1'b1;
        if (i_q == LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == KLAST) ? '0 : kidx_q + 1'b1;
          state_d = READ_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.addr  = addr_o;
  assign mem.wdata = wdata_o;
  assign mem.wren  = wren_o;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- RC4 key-scheduling stage, directly downstream of the one-shot start pulse generator.
- On a start pulse, initialises the 256-byte S-array RAM to the identity permutation (S[i]=i).
- Then runs the RC4 KSA swap loop using the secret key, and flags completion to the decryption stage.
- Sole master of the S-array RAM port while busy.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes; key index cycles 0..KEY_BYTES-1.
- ADDR_W, 8, S-array address width (256 entries); data width fixed at 8.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start request from the start pulse generator
- secret_key  in  KEY_BYTES*8  key, byte 0 = most-significant byte; must be stable while busy
- mem_addr  out  ADDR_W  S-array RAM address
- mem_wdata  out  8  S-array RAM write data
- mem_wren  out  1  S-array RAM write enable
- mem_rdata  in  8  S-array RAM read data, valid the cycle after the read address is presented (synchronous RAM, 1-cycle latency)
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  high while in DONE

Behaviour:
- Reset (async, any time, including mid-operation):
  - State=IDLE; i, j, key index, si, sj = 0.
  - mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, done=0.
  - No write may occur in the cycle following reset release.
- Outputs decode from state/registers only; no combinational path from start or mem_rdata to outputs.
- IDLE: start=1 -> INIT with i=0; start=0 -> stay.
- INIT:
  - mem_addr=i, mem_wdata=i, mem_wren=1; i<=i+1.
  - At i==255, after the write: i<=0, j<=0, key index<=0 -> READ_SI.
- READ_SI: mem_addr=i, mem_wren=0 -> WAIT_SI.
- WAIT_SI: si<=mem_rdata; j<=(j + mem_rdata + key[kidx]) mod 256 (8-bit wrap) -> READ_SJ.
- READ_SJ: mem_addr=j (new value), mem_wren=0 -> WAIT_SJ.
- WAIT_SJ: sj<=mem_rdata -> WRITE_SI.
- WRITE_SI: mem_addr=i, mem_wdata=sj, mem_wren=1 -> WRITE_SJ.
- WRITE_SJ: mem_addr=j, mem_wdata=si, mem_wren=1.
  - i==255 -> DONE.
  - Otherwise i<=i+1, kidx<=(kidx==KEY_BYTES-1)?0:kidx+1 -> READ_SI.
  - kidx is a wrap counter; no divider.
- DONE: done=1, busy=0. start=1 -> INIT with i=0 (done low next cycle); otherwise stay.
- start while busy: ignored; no effect on state, counters, or outputs.
- i==j: both swap writes hit the same address with equal data; legal, no special case.
- Key byte select: key[0]=secret_key[KEY_BYTES*8-1 -: 8], key[n] is the next byte down.
- Latency, with start sampled at edge k:
  - INIT occupies cycles k+1..k+256.
  - KSA takes 6 cycles/iteration x 256 = 1536 cycles: k+257..k+1792.
  - done=1 from cycle k+1793.
- Exactly 256 + 512 = 768 write cycles per run.

Test Plan:
- Reset, start pulse, key 0x000000 -> INIT writes mem[n]=n for n=0..255 on consecutive cycles; done rises exactly 1793 cycles after start; busy is high throughout.
- Key 0x000000, KSA phase:
  - i=0: writes addr0 data0 twice (i==j case).
  - i=2: writes addr2<-3, then addr3<-2.
  - i=3: writes addr3<-5, then addr5<-2.
  - Final RAM matches the golden RC4 KSA model.
- Key 0x010000 -> first KSA iteration computes j=1, writes addr0<-1 then addr1<-0; final RAM matches model.
- Extra start pulses at INIT cycle 10 and mid-KSA -> no restart; write sequence and done timing are identical to the unperturbed run.
- Assert rst mid-KSA (i=100) -> mem_wren=0, busy=0, done=0 immediately; a new start then produces a full correct run (1793-cycle latency).
- start pulse while in DONE -> done=0 the next cycle, INIT restarts at addr0, and the second run's final RAM equals the first run's.
